// File: rtl/ud_ctrl_pkg.sv
// Shared types and constants for the pushbutton up/down count front-end.
package ud_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS    = 3'd1,
        HOLD     = 3'd2,
        REPEAT   = 3'd3,
        WAIT_REL = 3'd4
    } ud_ctrl_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw pushbutton.
// Outputs the accepted (debounced) level and a one-cycle flag in the cycle
// that level first reads high.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The flip happens on the sample that would bring the count to
    // DEBOUNCE_CYCLES, so the counter itself never has to hold that value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Synchronize the raw input, then accept a new level only after it has
    // disagreed with the current one for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                rise_reg  <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/ud_count_ctrl.sv
// Pushbutton front-end for the saturating up/down counter: debounces the up
// and down buttons and issues single-cycle count strobes, never into a
// saturated limit.
// Optional feature macro: UD_CTRL_AUTO_REPEAT_EN enables auto-repeat while a
// button is held. Without it, each press yields exactly one strobe.
module ud_count_ctrl
    import ud_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 4096,
    parameter int REPEAT_RATE     = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic at_max,
    input  logic at_min,
    output logic count_en,
    output logic count_up1_dwn0,
    output logic busy
);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0] raw;
    logic [1:0] level;
    logic [1:0] rise;

    assign raw = {btn_dn, btn_up};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .reset(reset),
                .raw  (raw[gi]),
                .level(level[gi]),
                .rise (rise[gi])
            );
        end
    endgenerate

    logic up_level;
    logic dn_level;
    logic up_rise;
    logic dn_rise;

    assign up_level = level[0];
    assign dn_level = level[1];
    assign up_rise  = rise[0];
    assign dn_rise  = rise[1];

    ud_ctrl_state_t state_reg;
    ud_ctrl_state_t state_next;
    logic           dir_reg;
    logic           dir_next;
    logic           pulse_next;
    logic           count_en_reg;
    logic           count_dir_reg;

`ifdef UD_CTRL_AUTO_REPEAT_EN
    localparam int TIMER_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

    logic [TIMER_W-1:0] timer_reg;
    logic [TIMER_W-1:0] timer_next;
    logic               active_level;
    logic               opposite_level;

    assign active_level   = (dir_reg == DIR_UP) ? up_level : dn_level;
    assign opposite_level = (dir_reg == DIR_UP) ? dn_level : up_level;

    // Repeat timer: loaded on PRESS/REPEAT, counts down through HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_next;
        end
    end
`endif

    // FSM state, active direction and the registered strobe/direction outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            dir_reg       <= DIR_DN;
            count_en_reg  <= 1'b0;
            count_dir_reg <= DIR_DN;
        end else begin
            state_reg    <= state_next;
            dir_reg      <= dir_next;
            count_en_reg <= pulse_next;
            if (pulse_next) begin
                count_dir_reg <= dir_next;
            end
        end
    end

    // Next-state logic; the strobe is decided on entry to PRESS/REPEAT so the
    // registered output is high during that state.
    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
`ifdef UD_CTRL_AUTO_REPEAT_EN
        timer_next = timer_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (up_rise && dn_rise) begin
                    state_next = WAIT_REL;
                end else if (up_rise && !dn_level) begin
                    state_next = PRESS;
                    dir_next   = DIR_UP;
                end else if (dn_rise && !up_level) begin
                    state_next = PRESS;
                    dir_next   = DIR_DN;
                end
            end
            PRESS: begin
`ifdef UD_CTRL_AUTO_REPEAT_EN
                timer_next = TIMER_W'(REPEAT_DELAY);
                state_next = HOLD;
`else
                state_next = WAIT_REL;
`endif
            end
`ifdef UD_CTRL_AUTO_REPEAT_EN
            HOLD: begin
                timer_next = timer_reg - 1'b1;
                if (!active_level) begin
                    state_next = IDLE;
                end else if (opposite_level) begin
                    state_next = WAIT_REL;
                end else if (timer_reg == TIMER_W'(1)) begin
                    state_next = REPEAT;
                end
            end
            REPEAT: begin
                timer_next = TIMER_W'(REPEAT_RATE);
                state_next = HOLD;
            end
`endif
            WAIT_REL: begin
                if (!up_level && !dn_level) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A saturated limit drops the strobe but the FSM still advances.
        pulse_next = ((state_next == PRESS) || (state_next == REPEAT)) &&
                     !((dir_next == DIR_UP) ? at_max : at_min);
    end

    assign count_en       = count_en_reg;
    assign count_up1_dwn0 = count_dir_reg;
    assign busy           = (state_reg != IDLE);

endmodule

// File: doc/ud_count_ctrl.md
# ud_count_ctrl

Pushbutton front-end that drives the saturating up/down counter's `count_en` / `count_up1_dwn0` inputs. Two raw, asynchronous buttons (up, down) are synchronized, debounced and edge-qualified. Each press yields exactly one single-cycle count pulse; holding a button yields an optional auto-repeat. The block sits between the chip's input pads and the counter, and takes the counter's saturation flags as feedback so no pulse is issued into a saturated limit.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples required to accept a new button level; legal range 2..65535.
- `REPEAT_DELAY`, 4096: hold cycles, counted from the first pulse, before the first repeat pulse.
- `REPEAT_RATE`, 1024: cycles between successive repeat pulses; must be ≥ 2.
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high; clears all state on a rising `clk` edge while high.
- `btn_up`  in  1  raw up button, asynchronous, active-high.
- `btn_dn`  in  1  raw down button, asynchronous, active-high.
- `at_max`  in  1  counter value equals all-ones.
- `at_min`  in  1  counter value equals zero.
- `count_en`  out  1  single-cycle count strobe, registered.
- `count_up1_dwn0`  out  1  direction, registered; valid whenever `count_en` is high.
- `busy`  out  1  high in every FSM state except IDLE.

## Operation
- **Synchronizer:** a 2-flop synchronizer per button.
- **Debounce:** per button, a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter resets whenever the synchronized level equals the debounced level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- **FSM states:** IDLE, PRESS, HOLD, REPEAT, WAIT_REL.
  - **IDLE:**
    - Debounced up rises with down low → PRESS, direction up.
    - Debounced down rises with up low → PRESS, direction down.
    - Both rise in the same cycle → WAIT_REL with no pulse.
  - **PRESS:** one cycle.
    - Asserts `count_en`, unless the limit in the travel direction is set (`at_max` for up, `at_min` for down).
    - Loads the repeat timer with REPEAT_DELAY, then → HOLD.
  - **HOLD:** the timer decrements each cycle.
    - Active button released → IDLE.
    - Opposite button pressed → WAIT_REL.
    - Timer reaches 1 → REPEAT.
  - **REPEAT:** one cycle.
    - Pulses exactly as PRESS does.
    - Reloads the timer with REPEAT_RATE, then → HOLD.
  - **WAIT_REL:** no pulses. → IDLE when both debounced levels are low.
- **Saturation:** a pulse suppressed by saturation still advances the FSM normally; the pulse is simply dropped.
- **`count_up1_dwn0`:** holds the last direction between pulses and resets to 0.
- **Timer width:** $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).

## Timing
- **Reset values:** `count_en`=0, `count_up1_dwn0`=0, `busy`=0, FSM=IDLE.
  - Synchronizer flops, debounced levels and all counters clear to 0.
  - A button already held when `reset` deasserts is seen as a new press once debounced.
- **Press latency:** a raw level stable from cycle 0 gives `count_en` high in cycle DEBOUNCE_CYCLES+3.
  - 2 cycles for the synchronizer.
  - DEBOUNCE_CYCLES cycles for the debounce.
  - 1 cycle for the registered output.
- **Release latency:** a release propagates to the FSM with the same DEBOUNCE_CYCLES+2 latency as a press.
- **Pulse width:** `count_en` is never high for two consecutive cycles.
- **Repeat spacing:**
  - The first repeat pulse is REPEAT_DELAY+1 cycles after the PRESS pulse.
  - Subsequent repeat pulses are REPEAT_RATE+1 cycles apart.
- **Reset mid-operation:** `reset` asserted in any state forces the reset values on the next edge, with no partial pulse.

## Configuration
- Macro `UD_CTRL_AUTO_REPEAT_EN`.
- **Defined:** HOLD/REPEAT behave as above.
- **Undefined:**
  - PRESS goes directly to WAIT_REL, so one press gives exactly one pulse regardless of hold time.
  - The repeat timer and the REPEAT state are not synthesized.
  - REPEAT_DELAY and REPEAT_RATE are ignored.

## Structure
- **Package `ud_ctrl_pkg`:**
  - State enum `ud_ctrl_state_t` (IDLE, PRESS, HOLD, REPEAT, WAIT_REL).
  - Direction constants `DIR_UP`=1'b1, `DIR_DN`=1'b0.
- **Sub-module `btn_debounce`:** synchronizer plus debounce, with parameter DEBOUNCE_CYCLES. It is instantiated twice, and outputs the debounced level and a one-cycle rising-edge flag.

## Test plan
Parameters for all scenarios unless stated: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5; counter mid-range (`at_max`=`at_min`=0).
1. **Single press:** `btn_up` high from cycle 10 for 8 cycles → exactly one `count_en` pulse, at cycle 17, with `count_up1_dwn0`=1.
2. **Bounce rejection:** `btn_dn` toggles every 2 cycles for 20 cycles, then stays high → no pulse during the toggling; one pulse 7 cycles after the final rising edge.
3. **Auto-repeat:** `btn_up` held 60 cycles.
   - With the macro: pulses at P, P+21, P+27, P+33 and so on until release.
   - Without the macro: only the pulse at P.
4. **Saturation:** `at_max`=1 and `btn_up` pressed → no pulse, `busy` high. Then `btn_dn` pressed with `at_min`=0 → one pulse with `count_up1_dwn0`=0.
5. **Simultaneous buttons:** both buttons rise in the same cycle → no pulse, WAIT_REL until both are low; a following `btn_dn` press gives one down pulse.
6. **Mid-hold reset:** `reset` asserted in HOLD → next cycle FSM=IDLE, `count_en`=0, `busy`=0. With `btn_up` still held, one new pulse arrives DEBOUNCE_CYCLES+3 cycles after `reset` drops.
